// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline sequencing controller. It combines
//               load-use, branch, memory-stall and halt-drain events into a
//               single set of per-stage load enables and flushes.
//               Optional performance counters: define PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_ld_use,
    input  logic                 ex_br_taken,
    input  logic                 id_halt,
    input  logic                 imem_stall,
    input  logic                 dmem_stall,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam int         c_DCNT_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [1:0] c_S_RUN    = 2'd0;
    localparam logic [1:0] c_S_DRAIN  = 2'd1;
    localparam logic [1:0] c_S_HALTED = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_DCNT_W-1:0] r_drain_cnt;
    logic [c_DCNT_W-1:0] w_drain_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        pc_en           = 1'b0;
        ifid_en         = 1'b0;
        idex_en         = 1'b0;
        exmem_en        = 1'b0;
        memwb_en        = 1'b0;
        ifid_flush      = 1'b0;
        idex_flush      = 1'b0;
        halted          = 1'b0;
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;

        if (!rst) begin
            case (r_state)
                c_S_RUN: begin
                    // A data-memory stall freezes every stage; other events wait.
                    if (dmem_stall) begin
                        pc_en = 1'b0;
                    end else if (ex_br_taken) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (id_ld_use) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (id_halt) begin
                        ifid_en         = 1'b1;
                        idex_en         = 1'b1;
                        exmem_en        = 1'b1;
                        memwb_en        = 1'b1;
                        w_state_nxt     = c_S_DRAIN;
                        w_drain_cnt_nxt = '0;
                    end else if (imem_stall) begin
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                c_S_DRAIN: begin
                    if (dmem_stall) begin
                        pc_en = 1'b0;
                    end else if (ex_br_taken) begin
                        // The halt was fetched down a mispredicted path.
                        pc_en           = 1'b1;
                        ifid_en         = 1'b1;
                        idex_en         = 1'b1;
                        exmem_en        = 1'b1;
                        memwb_en        = 1'b1;
                        ifid_flush      = 1'b1;
                        idex_flush      = 1'b1;
                        w_state_nxt     = c_S_RUN;
                        w_drain_cnt_nxt = '0;
                    end else begin
                        ifid_en         = 1'b1;
                        ifid_flush      = 1'b1;
                        idex_en         = 1'b1;
                        exmem_en        = 1'b1;
                        memwb_en        = 1'b1;
                        w_drain_cnt_nxt = r_drain_cnt + c_DCNT_W'(1);
                        if (r_drain_cnt == c_DCNT_W'(DRAIN_CYCLES - 1)) begin
                            w_state_nxt = c_S_HALTED;
                        end
                    end
                end
                c_S_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_nxt     = c_S_RUN;
                    w_drain_cnt_nxt = '0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;
    logic                 w_stall_inc;
    logic                 w_flush_inc;

    assign w_stall_inc = (r_state == c_S_RUN) && !pc_en;
    assign w_flush_inc = (r_state != c_S_HALTED) && !dmem_stall && ex_br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall_inc && !(&r_stall_cycles)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (w_flush_inc && !(&r_flush_count)) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int CW = 16;

    // Packed outputs: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, halted}
    localparam logic [7:0] O_ZERO  = 8'h00;
    localparam logic [7:0] O_IDLE  = 8'hF8;
    localparam logic [7:0] O_LDUSE = 8'h3A;
    localparam logic [7:0] O_BR    = 8'hFE;
    localparam logic [7:0] O_IMEM  = 8'h7C;
    localparam logic [7:0] O_HACC  = 8'h78;
    localparam logic [7:0] O_DRAIN = 8'h7C;
    localparam logic [7:0] O_HALT  = 8'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_ld_use = 1'b0;
    logic          ex_br_taken = 1'b0;
    logic          id_halt = 1'b0;
    logic          imem_stall = 1'b0;
    logic          dmem_stall = 1'b0;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, halted;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_ld_use    (id_ld_use),
        .ex_br_taken  (ex_br_taken),
        .id_halt      (id_halt),
        .imem_stall   (imem_stall),
        .dmem_stall   (dmem_stall),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    // Inputs {ld_use, br, halt, imem, dmem} applied at negedge, outputs checked 1 ns later.
    task automatic step(input string tag, input logic [4:0] in, input logic [7:0] exp);
        logic [7:0] got;
        @(negedge clk);
        {id_ld_use, ex_br_taken, id_halt, imem_stall, dmem_stall} = in;
        #1;
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        logic [CW-1:0] es, ef;
`ifdef PIPE_CTRL_PERF_EN
        es = CW'(exp_stall);
        ef = CW'(exp_flush);
`else
        es = '0;
        ef = '0;
`endif
        n_vec++;
        assert (stall_cycles === es && flush_count === ef) else begin
            n_err++;
            $error("FAIL %s: observed stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   tag, stall_cycles, flush_count, es, ef);
        end
    endtask

    initial begin
        // Reset cycle
        rst = 1'b1;
        step("reset_outputs", 5'b00000, O_ZERO);
        step("reset_outputs_busy_in", 5'b11111, O_ZERO);
        @(negedge clk);
        rst = 1'b0;
        {id_ld_use, ex_br_taken, id_halt, imem_stall, dmem_stall} = 5'b00000;
        #1;
        chk_cnt("reset_counters");
        // Idle run
        for (int i = 0; i < 5; i++) step("idle", 5'b00000, O_IDLE);

        // Load-use bubble
        step("ld_use", 5'b10000, O_LDUSE);
        exp_stall++;
        step("after_ld_use", 5'b00000, O_IDLE);

        // Branch beats load-use
        step("br_over_ld_use", 5'b11000, O_BR);
        exp_flush++;
        step("after_br", 5'b00000, O_IDLE);
        chk_cnt("cnt_after_br");

        // dmem stall masks a held branch for 4 cycles
        for (int i = 0; i < 4; i++) begin
            step("dmem_masks_br", 5'b01001, O_ZERO);
            exp_stall++;
        end
        step("br_after_dmem", 5'b01000, O_BR);
        exp_flush++;
        step("idle_after_dmem_br", 5'b00000, O_IDLE);
        chk_cnt("cnt_after_dmem_br");

        // imem stall alone
        step("imem_stall", 5'b00010, O_IMEM);
        exp_stall++;
        // Halt under load-use is not accepted
        step("halt_blocked_by_ld_use", 5'b10100, O_LDUSE);
        exp_stall++;
        step("after_blocked_halt", 5'b00000, O_IDLE);

        // Halt accepted (imem don't-care) then drain with a dmem stall on cycle 2
        step("halt_accept", 5'b00110, O_HACC);
        exp_stall++;
        step("drain1", 5'b00000, O_DRAIN);
        step("drain2_dmem", 5'b00001, O_ZERO);
        step("drain3_ignores_ld_imem", 5'b10010, O_DRAIN);
        step("drain4", 5'b00000, O_DRAIN);
        for (int i = 0; i < 10; i++) step("halted_hold", 5'b11111, O_HALT);
        chk_cnt("cnt_halted");

        // Reset exits HALTED
        rst = 1'b1;
        step("reset_from_halted", 5'b00000, O_ZERO);
        @(negedge clk);
        rst = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        chk_cnt("cnt_cleared");
        step("run_after_reset", 5'b00000, O_IDLE);

        // Halt then branch on first drain cycle returns to RUN
        step("halt_accept2", 5'b00100, O_HACC);
        exp_stall++;
        step("drain_branch", 5'b01000, O_BR);
        exp_flush++;
        for (int i = 0; i < 5; i++) step("run_after_wrong_path_halt", 5'b00000, O_IDLE);
        chk_cnt("cnt_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central sequencing controller for the five-stage pipeline.
- Drives the load-enable and flush controls of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. These are all width-parameterised enabled register banks.
- Resolves load-use stalls, taken-branch flushes, instruction/data memory stalls and halt draining into one consistent set of per-cycle enables.
- All outputs are combinational from current inputs plus internal state. Internal state is registered on clk.

Parameters:
- DRAIN_CYCLES, 3, number of non-frozen cycles after halt acceptance before HALTED; covers EX, MEM, WB.
- CNT_WIDTH, 16, width of the performance counters (Optional Feature).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_ld_use  input  1  level; instruction in ID depends on a load in EX.
- ex_br_taken  input  1  level; EX resolves a taken branch/jump redirect.
- id_halt  input  1  level; valid HALT instruction in ID.
- imem_stall  input  1  level; instruction memory not returning a valid fetch this cycle.
- dmem_stall  input  1  level; data memory access in MEM not complete.
- pc_en  output  1  PC register load enable.
- ifid_en  output  1  IF/ID load enable.
- idex_en  output  1  ID/EX load enable.
- exmem_en  output  1  EX/MEM load enable.
- memwb_en  output  1  MEM/WB load enable.
- ifid_flush  output  1  IF/ID loads NOP/invalid instead of d; asserted only with ifid_en=1.
- idex_flush  output  1  ID/EX loads bubble; asserted only with idex_en=1.
- halted  output  1  pipeline fully drained and stopped.
- stall_cycles  output  CNT_WIDTH  cycles with pc_en=0 in RUN (Optional Feature).
- flush_count  output  CNT_WIDTH  count of taken-branch flushes (Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- During rst=1: all enables 0, all flushes 0, halted=0. On the next edge, state=RUN, drain counter=0, counters=0.
- FSM states:
  - RUN: normal operation.
  - DRAIN: halt accepted; no new fetch.
  - HALTED: stopped until rst.
- Per-cycle priority: dmem_stall > ex_br_taken > id_ld_use > imem_stall/id_halt.
  - dmem_stall=1 (any state except HALTED): all enables 0, all flushes 0. FSM and drain counter hold. Other inputs are ignored and re-evaluated on the next cycle; sources hold them level.
  - ex_br_taken=1 (RUN or DRAIN): all enables 1, ifid_flush=1, idex_flush=1. PC loads the target. In DRAIN, the halt was on the wrong path: next state=RUN, drain counter cleared.
  - id_ld_use=1, RUN: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1, memwb_en=1. A HALT in ID under a load-use hazard is not accepted until the hazard clears.
  - imem_stall=1, RUN, no higher event: pc_en=0, ifid_en=1 with ifid_flush=1, downstream enables 1.
  - id_halt=1, RUN, no higher event: halt accepted.
    - This cycle: pc_en=0, all other enables 1, idex_flush=0 (HALT proceeds down the pipe).
    - Next state=DRAIN, drain counter=0.
    - imem_stall is don't-care on the accepting cycle.
  - RUN with no events: all enables 1, flushes 0.
- DRAIN:
  - pc_en=0, ifid_en=1 with ifid_flush=1; idex/exmem/memwb enables 1.
  - Each non-dmem-stall, non-branch cycle increments the drain counter.
  - When the counter reaches DRAIN_CYCLES-1 on a counting cycle, next state=HALTED.
  - id_ld_use and imem_stall are ignored in DRAIN.
- HALTED: all enables 0, flushes 0, halted=1. All inputs are ignored; only rst exits.
- Flush outputs are never asserted with their enable low.
- Drain counter width is $clog2(DRAIN_CYCLES+1); DRAIN_CYCLES>=1.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on each RUN cycle with pc_en=0, including dmem and load-use cycles.
  - flush_count increments on each cycle with ex_br_taken accepted (not masked by dmem_stall).
  - Both counters saturate at all-ones and clear on rst.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesised.

Test Plan:
- Reset then 5 idle cycles -> cycle 0 under rst: all outputs 0; afterwards all enables 1, flushes 0, halted=0.
- id_ld_use=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; next cycle all enables 1.
- id_ld_use=1 and ex_br_taken=1 in the same cycle -> all enables 1, ifid_flush=idex_flush=1. With PERF_EN: flush_count=1, stall_cycles unchanged.
- dmem_stall=1 for 4 cycles with ex_br_taken=1 held -> 4 cycles all enables 0; on the 5th cycle the branch flush is applied once.
- id_halt=1 in RUN, DRAIN_CYCLES=3, dmem_stall=1 on the 2nd drain cycle -> halted rises after exactly 4 cycles of DRAIN; halted stays 1 and enables stay 0 for 10 further cycles until rst.
- id_halt accepted, then ex_br_taken=1 on the first DRAIN cycle -> flush asserted, state returns to RUN, halted never asserts, pc_en=1 on the following cycle.
